// File: rtl/arith_share_arbiter.sv
// -----------------------------------------------------------------------------
// arith_share_arbiter
//
// Shares one add/multiply unit among NUM_REQ requesters. A round-robin arbiter
// picks one requester per IDLE cycle; the granted operands are captured and
// either added (one cycle) or multiplied by a shift-add loop (DATA_W cycles).
// The result is returned on a single valid/ready channel tagged with the id of
// the requester that issued it.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req_valid   per-requester request valid
//   req_ready   per-requester accept, one-hot or zero, only high in IDLE
//   req_op      per-requester opcode: 0 = add, 1 = multiply
//   req_a/b     packed operands, requester i at [i*DATA_W +: DATA_W]
//   rsp_valid   result valid (held until rsp_ready)
//   rsp_ready   result consumer ready
//   rsp_id      id of the requester owning the result
//   rsp_result  2*DATA_W-bit result
//   busy        high whenever the unit is not idle
// -----------------------------------------------------------------------------
module arith_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_op,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [2*DATA_W-1:0]       rsp_result,
    output logic                      busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        MUL  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]     a_q, a_d;
    logic [DATA_W-1:0]     b_q, b_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [2*DATA_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
    logic [2*DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic                  busy_q, busy_d;

    // Unpacked per-requester operand views
    logic [DATA_W-1:0] a_arr [NUM_REQ];
    logic [DATA_W-1:0] b_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*DATA_W +: DATA_W];
            assign b_arr[gi] = req_b[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    logic            found;
    logic [ID_W-1:0] winner;

    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            idx = int'(rr_ptr_q) + j;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    // Grant is combinational so a requester sees its accept in the same cycle.
    assign req_ready = (state_q == IDLE && found) ? (NUM_REQ'(1) << winner) : '0;

    // Shift-add partial product for the current multiplier bit
    logic [2*DATA_W-1:0] addend;
    logic [DATA_W:0]     sum;

    always_comb begin
        addend = b_q[count_q] ? ({{DATA_W{1'b0}}, a_q} << count_q) : '0;
        sum    = {1'b0, a_q} + {1'b0, b_q};
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        acc_d        = acc_q;
        count_d      = count_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    a_d      = a_arr[winner];
                    b_d      = b_arr[winner];
                    id_d     = winner;
                    acc_d    = '0;
                    count_d  = '0;
                    rr_ptr_d = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
                    state_d  = req_op[winner] ? MUL : ADD;
                end
            end
            ADD: begin
                // Sum is one bit wider than the operands so the carry survives.
                rsp_result_d = (2*DATA_W)'(sum);
                rsp_id_d     = id_q;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            MUL: begin
                acc_d   = acc_q + addend;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(DATA_W - 1)) begin
                    rsp_result_d = acc_q + addend;
                    rsp_id_d     = id_q;
                    rsp_valid_d  = 1'b1;
                    count_d      = '0;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= '0;
            acc_q        <= '0;
            count_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            busy_q       <= busy_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_arith_share_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for arith_share_arbiter (NUM_REQ = 4, DATA_W = 8).
// Each scenario task drives stimulus and checks results against values derived
// from plain arithmetic and a round-robin selection model.
// -----------------------------------------------------------------------------
module tb_arith_share_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   req_op = '0;
    logic [NR*DW-1:0] req_a = '0;
    logic [NR*DW-1:0] req_b = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [1:0]      rsp_id;
    logic [2*DW-1:0] rsp_result;
    logic            busy;

    int errors = 0;
    int checks = 0;

    arith_share_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Reference round-robin choice: first set bit at or after ptr, wrapping.
    function automatic int rr_pick(input logic [NR-1:0] mask, input int ptr);
        for (int j = 0; j < NR; j++) begin
            if (mask[(ptr + j) % NR]) return (ptr + j) % NR;
        end
        return -1;
    endfunction

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issues one request and returns observed latency (negedges after the
    // handshake cycle), result and id. lat = -1 on timeout.
    task automatic run_txn(input int id, input bit op, input logic [7:0] a, input logic [7:0] b,
                           output int lat, output logic [15:0] res, output int rid);
        int n;
        lat = -1; res = '0; rid = -1; n = 0;
        @(negedge clk);
        req_a[id*DW +: DW] = a;
        req_b[id*DW +: DW] = b;
        req_op[id]         = op;
        req_valid[id]      = 1'b1;
        rsp_ready          = 1'b1;
        #1;
        while (req_ready[id] !== 1'b1 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 50) begin
            req_valid[id] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                lat = k; res = rsp_result; rid = int'(rsp_id);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
        checks++; if (rsp_result !== 16'd0) begin errors++; $display("FAIL reset_rsp_result: got %0d expected 0", rsp_result); end
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        do_reset();
        $display("test_reset done");
    endtask

    task automatic test_add_basic();
        int lat, rid; logic [15:0] res;
        run_txn(0, 1'b0, 8'd10, 8'd99, lat, res, rid);
        checks++; if (lat != 2) begin errors++; $display("FAIL add_latency: got %0d expected 2", lat); end
        checks++; if (rid != 0) begin errors++; $display("FAIL add_id: got %0d expected 0", rid); end
        checks++; if (res !== 16'd109) begin errors++; $display("FAIL add_result: got %0d expected 109", res); end
        $display("txn add req0 10+99 -> %0d lat %0d", res, lat);
    endtask

    task automatic test_mul();
        logic [7:0]  av [3] = '{8'd10, 8'd132, 8'd255};
        logic [7:0]  bv [3] = '{8'd99, 8'd33, 8'd255};
        logic [15:0] ev [3] = '{16'd990, 16'd4356, 16'd65025};
        int lat, rid; logic [15:0] res;
        for (int t = 0; t < 3; t++) begin
            run_txn(2, 1'b1, av[t], bv[t], lat, res, rid);
            checks++; if (lat != DW + 1) begin errors++; $display("FAIL mul_latency[%0d]: got %0d expected %0d", t, lat, DW + 1); end
            checks++; if (rid != 2) begin errors++; $display("FAIL mul_id[%0d]: got %0d expected 2", t, rid); end
            checks++; if (res !== ev[t]) begin errors++; $display("FAIL mul_result[%0d]: got %0d expected %0d", t, res, ev[t]); end
            $display("txn mul req2 %0d*%0d -> %0d lat %0d", av[t], bv[t], res, lat);
        end
    endtask

    task automatic test_edges();
        int lat, rid; logic [15:0] res;
        run_txn(1, 1'b0, 8'd255, 8'd255, lat, res, rid);
        checks++; if (res !== 16'd510) begin errors++; $display("FAIL add_carry: got %0d expected 510", res); end
        $display("txn add req1 255+255 -> %0d", res);
        run_txn(3, 1'b1, 8'd0, 8'd200, lat, res, rid);
        checks++; if (res !== 16'd0 || rid != 3) begin errors++; $display("FAIL mul_zero: got %0d id %0d expected 0 id 3", res, rid); end
        $display("txn mul req3 0*200 -> %0d", res);
    endtask

    task automatic test_round_robin();
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int grants = 0, resps = 0, busy_bad = 0, got_id;
        bit in_txn = 0;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            req_a[i*DW +: DW] = 8'(i + 1);
            req_b[i*DW +: DW] = 8'(10 * i);
            req_op[i] = 1'b0;
        end
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && resps < 5; cyc++) begin
            #1;
            if (in_txn && busy !== 1'b1) busy_bad++;
            if (rsp_valid === 1'b1) begin
                got_id = int'(rsp_id);
                checks++;
                if (got_id != exp_order[resps] || rsp_result !== 16'((exp_order[resps] + 1) + 10 * exp_order[resps])) begin
                    errors++;
                    $display("FAIL rr_rsp[%0d]: got id %0d res %0d expected id %0d res %0d", resps, got_id, rsp_result,
                             exp_order[resps], (exp_order[resps] + 1) + 10 * exp_order[resps]);
                end
                $display("txn rr rsp id %0d res %0d", got_id, rsp_result);
                resps++;
                in_txn = 0;
            end
            if (req_ready !== 4'b0) begin
                checks++;
                if (grants >= 5 || req_ready !== (4'b1 << exp_order[grants])) begin
                    errors++;
                    $display("FAIL rr_grant[%0d]: got %b expected onehot bit %0d", grants, req_ready,
                             exp_order[grants % 5]);
                end
                grants++;
                in_txn = 1;
            end
            @(negedge clk);
        end
        req_valid = '0;
        checks++; if (grants != 5 || resps != 5) begin errors++; $display("FAIL rr_count: got %0d grants %0d rsps expected 5 5", grants, resps); end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL rr_busy: got %0d cycles busy low expected 0", busy_bad); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [1:0]  hold_id;
        logic [15:0] hold_res;
        int n = 0;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_a[1*DW +: DW] = 8'd7; req_b[1*DW +: DW] = 8'd8; req_op[1] = 1'b0;
        req_valid = 4'b0010;
        #1;
        while (req_ready[1] !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        req_a[3*DW +: DW] = 8'd1; req_b[3*DW +: DW] = 8'd2; req_op[3] = 1'b0;
        req_valid[3] = 1'b1;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        hold_id = rsp_id; hold_res = rsp_result;
        checks++; if (rsp_valid !== 1'b1 || hold_id !== 2'd1 || hold_res !== 16'd15) begin
            errors++; $display("FAIL bp_first: got valid %b id %0d res %0d expected 1 1 15", rsp_valid, hold_id, hold_res);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== hold_id || rsp_result !== hold_res || req_ready !== 4'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid %b id %0d res %0d ready %b expected 1 %0d %0d 0000",
                         c, rsp_valid, rsp_id, rsp_result, req_ready, hold_id, hold_res);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_release: got valid %b busy %b expected 0 0", rsp_valid, busy);
        end
        $display("txn bp req1 7+8 -> %0d held 5 cycles", hold_res);
        n = 0;
        while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        req_valid[3] = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++; if (rsp_id !== 2'd3 || rsp_result !== 16'd3) begin
            errors++; $display("FAIL bp_next: got id %0d res %0d expected 3 3", rsp_id, rsp_result);
        end
        $display("txn bp req3 1+2 -> %0d", rsp_result);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_mul();
        int n = 0, seen = 0;
        @(negedge clk);
        rsp_ready = 1'b1;
        req_a[1*DW +: DW] = 8'd200; req_b[1*DW +: DW] = 8'd77; req_op[1] = 1'b1;
        req_valid = 4'b0010;
        #1;
        while (req_ready[1] !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (4) @(posedge clk);
        #2;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_mul_busy: got %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_result !== 16'd0 || rsp_id !== 2'd0) begin
            errors++; $display("FAIL async_reset: got valid %b busy %b res %0d id %0d expected all 0", rsp_valid, busy, rsp_result, rsp_id);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL aborted_rsp: got %0d valid cycles expected 0", seen); end
        for (int i = 0; i < NR; i++) req_op[i] = 1'b0;
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL post_reset_grant: got %b expected 0001", req_ready); end
        $display("txn reset mid-mul, first grant %b", req_ready);
        @(posedge clk); #1;
        req_valid = '0;
        n = 0;
        while (busy !== 1'b0 && n < 30) begin @(negedge clk); n++; end
        @(negedge clk);
    endtask

    task automatic test_random();
        bit          pend [NR];
        logic        op_t [NR];
        logic [7:0]  a_t  [NR];
        logic [7:0]  b_t  [NR];
        int          exp_id [$];
        logic [15:0] exp_res [$];
        int ptr = 0, done = 0, e, oid;
        logic [15:0] eres;
        do_reset();
        for (int i = 0; i < NR; i++) begin pend[i] = 0; op_t[i] = 0; a_t[i] = 0; b_t[i] = 0; end
        for (int cyc = 0; cyc < 4000 && done < 40; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1;
                    op_t[i] = 1'($urandom_range(0, 1));
                    a_t[i]  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
                    b_t[i]  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                end else if (pend[i] && $urandom_range(0, 31) == 0) begin
                    pend[i] = 0;
                end
                req_valid[i] = pend[i];
                req_op[i] = op_t[i];
                req_a[i*DW +: DW] = a_t[i];
                req_b[i*DW +: DW] = b_t[i];
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (rsp_valid === 1'b1 && rsp_ready) begin
                checks++;
                oid = int'(rsp_id);
                if (exp_id.size() == 0) begin
                    errors++; $display("FAIL rnd_rsp: got id %0d res %0d expected no response", oid, rsp_result);
                end else begin
                    if (oid != exp_id[0] || rsp_result !== exp_res[0]) begin
                        errors++; $display("FAIL rnd_rsp[%0d]: got id %0d res %0d expected id %0d res %0d",
                                           done, oid, rsp_result, exp_id[0], exp_res[0]);
                    end
                    void'(exp_id.pop_front());
                    void'(exp_res.pop_front());
                end
                $display("txn rnd rsp %0d id %0d res %0d", done, oid, rsp_result);
                done++;
            end
            if (req_ready !== 4'b0) begin
                e = rr_pick(req_valid, ptr);
                checks++;
                if (e < 0 || req_ready !== (4'b1 << e)) begin
                    errors++; $display("FAIL rnd_grant: got %b expected winner %0d valid %b", req_ready, e, req_valid);
                end
                if (e >= 0) begin
                    eres = op_t[e] ? 16'(a_t[e]) * 16'(b_t[e]) : 16'(a_t[e]) + 16'(b_t[e]);
                    exp_id.push_back(e);
                    exp_res.push_back(eres);
                    ptr = (e + 1) % NR;
                    pend[e] = 0;
                end
            end
        end
        req_valid = '0;
        checks++; if (done < 40) begin errors++; $display("FAIL rnd_timeout: got %0d responses expected 40", done); end
        rsp_ready = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_mul();
        test_edges();
        test_round_robin();
        test_backpressure();
        test_reset_mid_mul();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
